// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port PSRAM arbiter, fixed A priority with B anti-starvation
//
// Shares one PSRAM controller port between requester A (cartridge bus path)
// and requester B (loader/DMA path). A wins ties unless B has watched
// STARVE_MAX consecutive A grants, in which case B goes next.
//
// Optional feature macro: ARB_REFRESH_EN
//   defined   : free-running refresh timer, one owed refresh at a time,
//               served from IDLE ahead of any new access
//   undefined : no timer, no REFRESH state, mem_refresh tied low
//
// Ports
//   clk, reset_n                          clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata             port A request (level, held until a_ack)
//   a_rdata/a_ack                         port A read data and one-cycle completion
//   b_req/b_we/b_addr/b_wdata             port B request
//   b_rdata/b_ack                         port B read data and completion
//   mem_req/mem_we/mem_addr/mem_wdata     start strobe and held access fields
//   mem_rdata/mem_ready                   PSRAM read data and completion
//   mem_refresh                           one-cycle refresh strobe
//   busy                                  high whenever the FSM is not in IDLE
module mem_arbiter #(
    parameter int AW         = 23,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4,
    parameter int REF_CYCLES = 780
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    output logic          a_ack,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] b_rdata,
    output logic          b_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          mem_refresh,
    output logic          busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
`ifdef ARB_REFRESH_EN
    localparam logic [2:0] S_REFRESH = 3'd4;
`endif

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [2:0]    state;
    logic          owner_b;
    logic [SW-1:0] starve_cnt;
    logic          a_wins;

    // A keeps priority unless B is waiting and has already been passed over
    // STARVE_MAX times in a row.
    assign a_wins = a_req && !(b_req && (starve_cnt == STARVE_LIM));

`ifdef ARB_REFRESH_EN
    localparam int RW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REF_CYCLES - 1);

    logic [RW-1:0] ref_cnt;
    logic          ref_pend;
    logic          ref_done;

    assign ref_done = (state == S_REFRESH) && mem_ready;

    // A wrap always (re)arms ref_pend, so a wrap landing on the completion
    // cycle keeps the new period's refresh owed; extra wraps collapse into one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
            if (ref_done) begin
                ref_pend <= 1'b0;
            end
        end
    end
`else
    assign mem_refresh = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            owner_b    <= 1'b0;
            starve_cnt <= '0;
            a_rdata    <= '0;
            a_ack      <= 1'b0;
            b_rdata    <= '0;
            b_ack      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
`ifdef ARB_REFRESH_EN
            mem_refresh <= 1'b0;
`endif
        end else begin
            mem_req <= 1'b0;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
`ifdef ARB_REFRESH_EN
            mem_refresh <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
`ifdef ARB_REFRESH_EN
                    if (ref_pend) begin
                        state       <= S_REFRESH;
                        mem_refresh <= 1'b1;
                        busy        <= 1'b1;
                    end else
`endif
                    if (a_wins) begin
                        owner_b   <= 1'b0;
                        mem_we    <= a_we;
                        mem_addr  <= a_addr;
                        mem_wdata <= a_wdata;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                        if (b_req && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (b_req) begin
                        owner_b    <= 1'b1;
                        mem_we     <= b_we;
                        mem_addr   <= b_addr;
                        mem_wdata  <= b_wdata;
                        mem_req    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                        starve_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        if (owner_b) begin
                            b_rdata <= mem_rdata;
                            b_ack   <= 1'b1;
                        end else begin
                            a_rdata <= mem_rdata;
                            a_ack   <= 1'b1;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Ack is visible this cycle; requester drops req before IDLE samples.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
`ifdef ARB_REFRESH_EN
                S_REFRESH: begin
                    if (mem_ready) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
